// File: rtl/sc_matrix_max7219_driver.sv
// MAX7219 8x8 matrix driver: runs a 5-word controller init after reset, then on a
// load request latches eight row patterns and shifts them out as eight 16-bit SPI words.
module sc_matrix_max7219_driver #(
  parameter int         NUMBER_DATAWIDTH = 8,
  parameter int         CLKDIV           = 4,
  parameter logic [3:0] INTENSITY        = 4'h8
) (
  input  logic                        SC_MATRIX_CLOCK_50,
  input  logic                        SC_MATRIX_RESET_InHigh,
  input  logic [NUMBER_DATAWIDTH-1:0] SC_MATRIX_regGAME_data7_InBus,
  input  logic [NUMBER_DATAWIDTH-1:0] SC_MATRIX_regGAME_data6_InBus,
  input  logic [NUMBER_DATAWIDTH-1:0] SC_MATRIX_regGAME_data5_InBus,
  input  logic [NUMBER_DATAWIDTH-1:0] SC_MATRIX_regGAME_data4_InBus,
  input  logic [NUMBER_DATAWIDTH-1:0] SC_MATRIX_regGAME_data3_InBus,
  input  logic [NUMBER_DATAWIDTH-1:0] SC_MATRIX_regGAME_data2_InBus,
  input  logic [NUMBER_DATAWIDTH-1:0] SC_MATRIX_regGAME_data1_InBus,
  input  logic [NUMBER_DATAWIDTH-1:0] SC_MATRIX_regGAME_data0_InBus,
  input  logic                        SC_MATRIX_load_InLow,
  output logic                        SC_MATRIX_busy_Out,
  output logic                        SC_MATRIX_done_Out,
  output logic                        SC_MATRIX_max_din_Out,
  output logic                        SC_MATRIX_max_sclk_Out,
  output logic                        SC_MATRIX_max_cs_OutLow
);

  // Top-level sequencing
  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_FRAME = 2'd2;

  // Word engine phases; each value describes what the current cycle is doing.
  // PH_LAUNCH only follows reset: cs is still high and the next edge starts word 0.
  localparam logic [1:0] PH_LAUNCH = 2'd0;
  localparam logic [1:0] PH_WLOAD  = 2'd1;
  localparam logic [1:0] PH_SHIFT  = 2'd2;
  localparam logic [1:0] PH_GAP    = 2'd3;

  localparam int DIV_W = (CLKDIV > 1) ? $clog2(2 * CLKDIV) : 1;
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLKDIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'(2 * CLKDIV - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_q, bit_d;
  logic [2:0]       word_q, word_d;
  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic             din_q, din_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [NUMBER_DATAWIDTH-1:0] rows_q [8];
  logic [NUMBER_DATAWIDTH-1:0] rows_d [8];
  logic [NUMBER_DATAWIDTH-1:0] row_in [8];

  logic [2:0]  next_idx;
  logic [3:0]  bit_m1;
  logic        in_init;
  logic        last_word;
  logic [15:0] cur_word;
  logic [15:0] nxt_word;
  logic [15:0] first_word;

  assign row_in[0] = SC_MATRIX_regGAME_data0_InBus;
  assign row_in[1] = SC_MATRIX_regGAME_data1_InBus;
  assign row_in[2] = SC_MATRIX_regGAME_data2_InBus;
  assign row_in[3] = SC_MATRIX_regGAME_data3_InBus;
  assign row_in[4] = SC_MATRIX_regGAME_data4_InBus;
  assign row_in[5] = SC_MATRIX_regGAME_data5_InBus;
  assign row_in[6] = SC_MATRIX_regGAME_data6_InBus;
  assign row_in[7] = SC_MATRIX_regGAME_data7_InBus;

  // Init words are fixed; frame word k targets digit register k+1.
  function automatic logic [15:0] word_of(input logic init_sel, input logic [2:0] k,
                                          input logic [7:0] row);
    logic [15:0] w;
    w = 16'h0000;
    if (init_sel) begin
      case (k)
        3'd0:    w = 16'h0C01;
        3'd1:    w = 16'h0900;
        3'd2:    w = {8'h0A, 4'h0, INTENSITY};
        3'd3:    w = 16'h0B07;
        3'd4:    w = 16'h0F00;
        default: w = 16'h0000;
      endcase
    end else begin
      w = {4'h0, {1'b0, k} + 4'd1, row};
    end
    return w;
  endfunction

  assign next_idx   = word_q + 3'd1;
  assign bit_m1     = bit_q - 4'd1;
  assign in_init    = (state_q == ST_INIT);
  assign last_word  = in_init ? (word_q == 3'd4) : (word_q == 3'd7);
  assign cur_word   = word_of(in_init, word_q, 8'(rows_q[word_q]));
  assign nxt_word   = word_of(in_init, next_idx, 8'(rows_q[next_idx]));
  assign first_word = word_of(1'b0, 3'd0, 8'(row_in[0]));

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    div_d   = div_q;
    bit_d   = bit_q;
    word_d  = word_q;
    rows_d  = rows_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    din_d   = din_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        din_d  = 1'b0;
        busy_d = 1'b0;
        // Accepting edge latches the rows and already drops cs for word 0.
        if (!SC_MATRIX_load_InLow) begin
          rows_d  = row_in;
          state_d = ST_FRAME;
          busy_d  = 1'b1;
          word_d  = 3'd0;
          bit_d   = 4'd15;
          div_d   = '0;
          phase_d = PH_WLOAD;
          cs_d    = 1'b0;
          din_d   = first_word[15];
        end
      end

      ST_INIT, ST_FRAME: begin
        case (phase_q)
          PH_LAUNCH: begin
            cs_d    = 1'b0;
            sclk_d  = 1'b0;
            din_d   = cur_word[15];
            bit_d   = 4'd15;
            div_d   = '0;
            phase_d = PH_WLOAD;
          end

          PH_WLOAD, PH_SHIFT: begin
            phase_d = PH_SHIFT;
            if (div_q == HALF_LAST) begin
              div_d = '0;
              if (!sclk_q) begin
                sclk_d = 1'b1;
              end else if (bit_q == 4'd0) begin
                // Rising cs here is what latches the word inside the MAX7219.
                sclk_d  = 1'b0;
                cs_d    = 1'b1;
                din_d   = 1'b0;
                phase_d = PH_GAP;
              end else begin
                sclk_d = 1'b0;
                bit_d  = bit_m1;
                din_d  = cur_word[bit_m1];
              end
            end else begin
              div_d = div_q + DIV_W'(1);
            end
          end

          default: begin
            if (div_q == GAP_LAST) begin
              div_d = '0;
              if (last_word) begin
                state_d = ST_IDLE;
                phase_d = PH_LAUNCH;
                busy_d  = 1'b0;
                done_d  = (state_q == ST_FRAME);
                word_d  = 3'd0;
              end else begin
                word_d  = next_idx;
                bit_d   = 4'd15;
                phase_d = PH_WLOAD;
                cs_d    = 1'b0;
                din_d   = nxt_word[15];
              end
            end else begin
              div_d = div_q + DIV_W'(1);
            end
          end
        endcase
      end

      default: begin
        state_d = ST_INIT;
        phase_d = PH_LAUNCH;
        busy_d  = 1'b1;
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        din_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge SC_MATRIX_CLOCK_50) begin
    if (SC_MATRIX_RESET_InHigh) begin
      state_q <= ST_INIT;
      phase_q <= PH_LAUNCH;
      div_q   <= '0;
      bit_q   <= 4'd15;
      word_q  <= 3'd0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      din_q   <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      for (int i = 0; i < 8; i++) rows_q[i] <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rows_q  <= rows_d;
    end
  end

  assign SC_MATRIX_busy_Out      = busy_q;
  assign SC_MATRIX_done_Out      = done_q;
  assign SC_MATRIX_max_din_Out   = din_q;
  assign SC_MATRIX_max_sclk_Out  = sclk_q;
  assign SC_MATRIX_max_cs_OutLow = cs_q;

endmodule
